// File: rtl/fp_normalize_round_pkg.sv
// Shared types and constants for the FP adder post-ALU normalize/round stage.
package fp_pkg;

  localparam int         GRS_WIDTH = 3;
  localparam logic [7:0] EXP_MAX   = 8'hFF;
  localparam int         EXP_BIAS  = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } normState_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Handshake bundle between the ALU (producer), this stage, and the consumer.
// master = ALU/consumer side, slave = the normalize/round stage.
interface fp_normalize_round_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
);
  import fp_pkg::*;

  // ALU -> stage
  logic                          inValid;
  logic                          inReady;
  logic                          inSign;
  logic [EXP_WIDTH-1:0]          inExponent;
  logic                          inCarry;
  logic [FRAC_WIDTH:0]           inMantissa;
  logic [GRS_WIDTH-1:0]          inGRS;

  // stage -> consumer
  logic                          outValid;
  logic                          outReady;
  logic [EXP_WIDTH+FRAC_WIDTH:0] result;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output inValid, inSign, inExponent, inCarry, inMantissa, inGRS, outReady,
    input  inReady, outValid, result, overflow, underflow
  );

  modport slave (
    input  inValid, inSign, inExponent, inCarry, inMantissa, inGRS, outReady,
    output inReady, outValid, result, overflow, underflow
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized working mantissa W[26:0]
// ({hidden, fraction, G, R, S}). Returns the rounded mantissa with the
// hidden bit, already renormalized when rounding carried out of the top.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int FRAC_WIDTH = 23
) (
  input  logic [FRAC_WIDTH+GRS_WIDTH:0] w_i,
  output logic [FRAC_WIDTH:0]           mant_o,
  output logic                          carry_o
);

  localparam int SUM_WIDTH = FRAC_WIDTH + 2;

  logic                 lsb, guard, rnd, sticky, round_up;
  logic [SUM_WIDTH-1:0] sum;

  // Round up only above the halfway point, or exactly halfway with an odd LSB.
  always_comb begin
    // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
    lsb      = w_i[GRS_WIDTH];
    guard    = w_i[2];
    rnd      = w_i[1];
    sticky   = w_i[0];
    round_up = guard & (lsb | rnd | sticky);
    sum      = {1'b0, w_i[FRAC_WIDTH+GRS_WIDTH:GRS_WIDTH]} + SUM_WIDTH'(round_up);
    carry_o  = sum[SUM_WIDTH-1];
    // A carry out means the mantissa became exactly 10.000..., so shifting right loses nothing.
    mant_o   = carry_o ? sum[SUM_WIDTH-1:1] : sum[FRAC_WIDTH:0];
  end

endmodule

// File: rtl/fp_normalize_round.sv
// FP adder post-ALU stage: iterative one-bit-per-cycle normalization,
// RNE rounding and IEEE-754 packing, behind valid/ready handshakes.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_normalize_round_if.slave  bus
);

  localparam int W_WIDTH = FRAC_WIDTH + GRS_WIDTH + 2;  // carry + mantissa + GRS
  localparam int E_WIDTH = EXP_WIDTH + 2;               // headroom for +1 and underflow checks
  localparam int R_WIDTH = EXP_WIDTH + FRAC_WIDTH + 1;

  localparam logic [E_WIDTH-1:0] E_ONE = E_WIDTH'(1);
  localparam logic [E_WIDTH-1:0] E_SAT = {2'b00, {EXP_WIDTH{1'b1}}};

  normState_t           state_q;
  logic                 sign_q;
  logic [W_WIDTH-1:0]   w_q;
  logic [E_WIDTH-1:0]   e_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [R_WIDTH-1:0]   result_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic [FRAC_WIDTH:0]  m_rnd;
  logic                 m_carry;
  logic [E_WIDTH-1:0]   e_rnd;
  logic                 unused_hidden;

  fp_round_rne #(.FRAC_WIDTH(FRAC_WIDTH)) u_round (
    .w_i     (w_q[W_WIDTH-2:0]),
    .mant_o  (m_rnd),
    .carry_o (m_carry)
  );

  // Exponent after a possible rounding carry; the hidden bit itself is implicit in the packed result.
  assign e_rnd         = e_q + E_WIDTH'(m_carry);
  assign unused_hidden = m_rnd[FRAC_WIDTH];

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      w_q         <= '0;
      e_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.inValid && in_ready_q) begin
            w_q         <= {bus.inCarry, bus.inMantissa, bus.inGRS};
            e_q         <= E_WIDTH'(bus.inExponent);
            sign_q      <= bus.inSign;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            in_ready_q  <= 1'b0;
            state_q     <= NORM;
          end
        end

        NORM: begin
          if (w_q == '0) begin
            // Exact cancellation always yields +0.
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (w_q[W_WIDTH-1]) begin
            // Carry out: one right shift, folding the dropped bit into sticky.
            w_q     <= {1'b0, w_q[W_WIDTH-1:2], w_q[1] | w_q[0]};
            e_q     <= e_q + E_ONE;
            state_q <= ROUND;
          end else if (!w_q[W_WIDTH-2] && e_q == E_ONE) begin
            result_q    <= {sign_q, {(R_WIDTH-1){1'b0}}};
            underflow_q <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (!w_q[W_WIDTH-2]) begin
            w_q <= w_q << 1;
            e_q <= e_q - E_ONE;
          end else begin
            state_q <= ROUND;
          end
        end

        ROUND: begin
          if (e_rnd >= E_SAT) begin
            result_q   <= {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            overflow_q <= 1'b1;
          end else begin
            result_q <= {sign_q, e_rnd[EXP_WIDTH-1:0], m_rnd[FRAC_WIDTH-1:0]};
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          if (bus.outReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.inReady   = in_ready_q;
  assign bus.outValid  = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: scoreboard of expected
// results/latencies, backpressure, mid-operation reset and back-to-back use.
module tb_fp_normalize_round;
  import fp_pkg::*;

  localparam int LAT_LIMIT = 64;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic        c;
    logic [23:0] m;
    logic [2:0]  grs;
    logic [31:0] r;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        ov;
    logic        un;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  fp_normalize_round_if bus ();

  fp_normalize_round dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string name, input logic s, input logic [7:0] e,
                              input logic c, input logic [23:0] m, input logic [2:0] grs,
                              input logic [31:0] r, input logic ov, input logic un, input int lat);
    vec_t v;
    v.name = name; v.s = s; v.e = e; v.c = c; v.m = m; v.grs = grs;
    v.r = r; v.ov = ov; v.un = un; v.lat = lat;
    return v;
  endfunction

  // Drive one transfer (caller is #1 after an edge with the block idle) and push its expectation.
  task automatic send(input vec_t v);
    exp_t x;
    x.name = v.name; x.r = v.r; x.ov = v.ov; x.un = v.un; x.lat = v.lat;
    sb.push_back(x);
    bus.inSign     = v.s;
    bus.inExponent = v.e;
    bus.inCarry    = v.c;
    bus.inMantissa = v.m;
    bus.inGRS      = v.grs;
    bus.inValid    = 1'b1;
    @(posedge clk);
    #1;
    bus.inValid    = 1'b0;
  endtask

  // Count edges after the accept edge until outValid rises; bounded.
  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!bus.outValid && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.outValid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: outValid still %b after %0d cycles, need 1", name, bus.outValid, lat);
    end
  endtask

  task automatic handshake();
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    bus.outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.inReady, bus.outValid, bus.result, bus.overflow, bus.underflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got inReady=%b outValid=%b result=%h ov=%b un=%b, need 1 0 00000000 0 0",
               bus.inReady, bus.outValid, bus.result, bus.overflow, bus.underflow);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_datapath();
    vec_t vecs[$];
    exp_t x;
    int   lat;
    vecs.push_back(mk("normalized",   1'b0, 8'h7F, 1'b0, 24'h800000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 2));
    vecs.push_back(mk("carry_out",    1'b0, 8'h7F, 1'b1, 24'h000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 2));
    vecs.push_back(mk("round_ovf",    1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 3'b110, 32'h7F800000, 1'b1, 1'b0, 2));
    vecs.push_back(mk("carry_ovf",    1'b1, 8'hFF, 1'b1, 24'h000000, 3'b000, 32'hFF800000, 1'b1, 1'b0, 2));
    vecs.push_back(mk("cancel_23",    1'b0, 8'h85, 1'b0, 24'h000001, 3'b000, 32'h37000000, 1'b0, 1'b0, 25));
    vecs.push_back(mk("max_shift_26", 1'b0, 8'h7F, 1'b0, 24'h000000, 3'b001, 32'h32800000, 1'b0, 1'b0, 28));
    vecs.push_back(mk("one_shift",    1'b0, 8'h7F, 1'b0, 24'h7FFFFF, 3'b000, 32'h3F7FFFFE, 1'b0, 1'b0, 3));
    vecs.push_back(mk("rne_odd_tie",  1'b0, 8'h7F, 1'b0, 24'h800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2));
    vecs.push_back(mk("rne_even_tie", 1'b0, 8'h7F, 1'b0, 24'h800000, 3'b100, 32'h3F800000, 1'b0, 1'b0, 2));
    vecs.push_back(mk("rne_above",    1'b0, 8'h7F, 1'b0, 24'h800000, 3'b101, 32'h3F800001, 1'b0, 1'b0, 2));
    vecs.push_back(mk("sticky_tie",   1'b0, 8'h7F, 1'b1, 24'h000001, 3'b000, 32'h40000000, 1'b0, 1'b0, 2));
    vecs.push_back(mk("sticky_up",    1'b0, 8'h7F, 1'b1, 24'h000001, 3'b001, 32'h40000001, 1'b0, 1'b0, 2));
    vecs.push_back(mk("underflow_0",  1'b1, 8'h01, 1'b0, 24'h400000, 3'b000, 32'h80000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk("underflow_2",  1'b0, 8'h03, 1'b0, 24'h100000, 3'b000, 32'h00000000, 1'b0, 1'b1, 3));
    vecs.push_back(mk("zero_neg",     1'b1, 8'h00, 1'b0, 24'h000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1));
    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_out(vecs[i].name, lat);
      x = sb.pop_front();
      n_cmp++;
      if ({bus.result, bus.overflow, bus.underflow} !== {x.r, x.ov, x.un}) begin
        n_bad++;
        $display("FAIL %s result: got %h ov=%b un=%b, need %h ov=%b un=%b",
                 x.name, bus.result, bus.overflow, bus.underflow, x.r, x.ov, x.un);
      end
      n_cmp++;
      if (lat !== x.lat) begin
        n_bad++;
        $display("FAIL %s latency: got %0d cycles, need %0d", x.name, lat, x.lat);
      end
      n_cmp++;
      if (bus.inReady !== 1'b0) begin
        n_bad++;
        $display("FAIL %s busy: inReady=%b while result pending, need 0", x.name, bus.inReady);
      end
      handshake();
      n_cmp++;
      if ({bus.outValid, bus.inReady} !== 2'b01) begin
        n_bad++;
        $display("FAIL %s release: got outValid=%b inReady=%b, need 0 1", x.name, bus.outValid, bus.inReady);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t x;
    int   lat;
    send(mk("bp", 1'b1, 8'h80, 1'b0, 24'hC00000, 3'b000, 32'hC0400000, 1'b0, 1'b0, 2));
    wait_out("bp", lat);
    x = sb.pop_front();
    // A competing input must be ignored while the result is held.
    bus.inSign = 1'b0; bus.inExponent = 8'h10; bus.inCarry = 1'b0;
    bus.inMantissa = 24'h000000; bus.inGRS = 3'b000; bus.inValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.outValid, bus.inReady, bus.result, bus.overflow, bus.underflow} !== {1'b1, 1'b0, x.r, x.ov, x.un}) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got outValid=%b inReady=%b result=%h, need 1 0 %h",
                 c, bus.outValid, bus.inReady, bus.result, x.r);
      end
    end
    bus.inValid = 1'b0;
    handshake();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.outValid, bus.inReady} !== 2'b01) begin
        n_bad++;
        $display("FAIL bp_no_accept cycle %0d: got outValid=%b inReady=%b, need 0 1", c, bus.outValid, bus.inReady);
      end
    end
  endtask

  task automatic test_reset_mid();
    send(mk("rst_mid", 1'b0, 8'h85, 1'b0, 24'h000001, 3'b000, 32'h37000000, 1'b0, 1'b0, 25));
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb.pop_front());
    n_cmp++;
    if ({bus.outValid, bus.inReady, bus.result, bus.overflow, bus.underflow} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid: got outValid=%b inReady=%b result=%h ov=%b un=%b, need 0 1 00000000 0 0",
               bus.outValid, bus.inReady, bus.result, bus.overflow, bus.underflow);
    end
    repeat (30) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.outValid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid_discard: got outValid=%b after reset, need 0", bus.outValid);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t vecs[$];
    exp_t x;
    int   lat;
    vecs.push_back(mk("b2b_a", 1'b0, 8'h7F, 1'b0, 24'h800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2));
    vecs.push_back(mk("b2b_b", 1'b1, 8'h01, 1'b0, 24'h400000, 3'b000, 32'h80000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk("b2b_c", 1'b0, 8'h7F, 1'b1, 24'h000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 2));
    vecs.push_back(mk("b2b_d", 1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 3'b110, 32'h7F800000, 1'b1, 1'b0, 2));
    foreach (vecs[i]) begin
      // No idle cycle: send starts right after the previous handshake edge.
      send(vecs[i]);
      wait_out(vecs[i].name, lat);
      x = sb.pop_front();
      n_cmp++;
      if ({bus.result, bus.overflow, bus.underflow, lat} !== {x.r, x.ov, x.un, x.lat}) begin
        n_bad++;
        $display("FAIL %s: got %h ov=%b un=%b lat=%0d, need %h ov=%b un=%b lat=%0d",
                 x.name, bus.result, bus.overflow, bus.underflow, lat, x.r, x.ov, x.un, x.lat);
      end
      handshake();
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.inValid    = 1'b0;
    bus.inSign     = 1'b0;
    bus.inExponent = '0;
    bus.inCarry    = 1'b0;
    bus.inMantissa = '0;
    bus.inGRS      = '0;
    bus.outReady   = 1'b0;

    test_reset();
    test_datapath();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
Post-ALU stage of the FP adder. It accepts the raw sum/difference produced by the ALU: sign, exponent, carry, 24-bit mantissa with hidden bit, and guard/round/sticky. It normalizes iteratively, one bit per cycle, rounds to nearest-even, and emits a packed IEEE-754 single-precision result with overflow/underflow flags. It decouples the combinational front stages from the consumer with a valid/ready handshake.

Parameters:
EXP_WIDTH, 8, exponent field width (only the default is verified)
FRAC_WIDTH, 23, stored fraction width; mantissa input is FRAC_WIDTH+1 bits

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
inValid  input  1  ALU result valid
inReady  output  1  block can accept (high only in IDLE)
inSign  input  1  result sign from ALU
inExponent  input  EXP_WIDTH  larger operand exponent
inCarry  input  1  ALU carry out (mantissa bit 24)
inMantissa  input  FRAC_WIDTH+1  ALU mantissa, bit 23 = hidden position
inGRS  input  3  guard, round, sticky
outValid  output  1  result valid
outReady  input  1  consumer accepts result
result  output  32  {sign, exponent, fraction}
overflow  output  1  result saturated to infinity
underflow  output  1  result flushed to zero

Behaviour:
- Reset value: state IDLE, inReady=1, outValid=0, result=0, overflow=0, underflow=0, and all working registers 0. Reset mid-operation discards the operation; the block is in IDLE on the next cycle.
- Working mantissa W[27:0] = {inCarry, inMantissa, inGRS}. Target position: W[26]=1 and W[27]=0. The working exponent E is 10 bits, zero-extended.
- IDLE: a transfer occurs when inValid&&inReady; W, E, and sign are captured, and the next state is NORM. Inputs are ignored otherwise.
- NORM, evaluated once per cycle in this priority order:
  - W==0: result={0,31'b0}, so an exact cancellation gives +0. Go to DONE.
  - W[27]=1: W = W>>1 with new W[0]=W[1]|W[0] to keep sticky; E=E+1. Go to ROUND.
  - W[26]=0 and E==1: flush to {sign,31'b0}, underflow=1. Go to DONE.
  - W[26]=0: W=W<<1, E=E-1. Stay in NORM.
  - Otherwise go to ROUND.
- ROUND:
  - L=W[3], G=W[2], R=W[1], S=W[0]; up = G&(L|R|S).
  - M[24:0] = {0,W[26:3]} + up. If M[24]=1: M=M>>1, E=E+1.
  - If E>=255: result={sign,8'hFF,23'b0}, overflow=1.
  - Else result={sign,E[7:0],M[22:0]}.
  - Go to DONE.
- DONE: outValid=1. result and flags are held stable until outReady. When outValid&&outReady, go to IDLE and clear outValid; flags are held until the next capture.
- Latency from the accept edge to outValid high:
  - 2 cycles for an input already normalized or carry-out.
  - 2+n cycles for n left shifts, max 2+26.
  - 1 cycle for a zero result.
  - k+1 cycles for an underflow reached after k left shifts.
- No overlap: inReady=0 from accept until the DONE handshake completes. A new accept is possible the cycle after outValid&&outReady.
- outReady is don't-care outside DONE. inValid is don't-care outside IDLE.

Decomposition:
- Shared package fp_pkg holds:
  - typedef fp32_t struct {sign, exponent[7:0], fraction[22:0]}
  - typedef normState_t enum {IDLE, NORM, ROUND, DONE}
  - constants EXP_MAX=8'hFF, EXP_BIAS=127, GRS_WIDTH=3
- One natural sub-module: fp_round_rne. It is combinational, takes W[26:0] and returns the rounded 24-bit mantissa plus a mantissa-overflow bit. The FSM, registers and handshake stay in fp_normalize_round.

Test Plan:
1. Normalized input: sign0, exp 7F, carry0, mant 800000, GRS 000 -> result 3F800000. outValid exactly 2 cycles after accept, flags 0.
2. Carry-out: exp 7F, carry1, mant 000000 -> result 40000000 (2.0) in 2 cycles. Rounding boundary: exp FE, mant FFFFFF, GRS 110 -> round carry, E=FF -> 7F800000, overflow=1.
3. Cancellation: exp 85, mant 000001, GRS 000 -> 23 left shifts -> result 37000000, outValid 25 cycles after accept.
4. RNE ties: exp 7F, mant 800001, GRS 100 -> 3F800002. Mant 800000, GRS 100 -> 3F800000. GRS 101 -> 3F800001.
5. Underflow/zero:
   - sign1, exp 01, mant 400000 -> 80000000, underflow=1.
   - All-zero input with sign1 -> 00000000, outValid 1 cycle after accept.
6. Backpressure and reset:
   - Hold outReady=0 for 5 cycles in DONE: result stable, inReady=0, a new inValid is not accepted.
   - Assert reset during scenario 3 shifting: next cycle outValid=0, inReady=1, result=0.
